// File: rtl/user_timer_multi.sv
// Multi-channel Avalon-MM interval timer. NUM_CH prescaled down-counters share one 16-bit
// register window per channel. All channel interrupts are OR-ed onto irq and are also visible together in PENDING.
module user_timer_multi #(
    parameter int          NUM_CH       = 2,
    parameter int          COUNT_W      = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h0098_967F,
    parameter int          PRESC_W      = 8,
    localparam int         AW           = $clog2(NUM_CH) + 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] address,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [15:0]   writedata,
    output logic [15:0]   readdata,
    output logic          irq
);

    typedef enum logic [2:0] {
        REG_STATUS   = 3'd0,
        REG_CONTROL  = 3'd1,
        REG_PERIOD_L = 3'd2,
        REG_PERIOD_H = 3'd3,
        REG_SNAP_L   = 3'd4,
        REG_SNAP_H   = 3'd5,
        REG_PRESCALE = 3'd6,
        REG_PENDING  = 3'd7
    } reg_e;

    localparam logic [COUNT_W-1:0] RESET_COUNT = RESET_PERIOD[COUNT_W-1:0];

    logic              w_wr;
    logic [3:0]        w_ch;
    logic              w_ch_valid;
    reg_e              w_reg;
    logic [NUM_CH-1:0] w_irq;
    logic [15:0]       w_ch_rdata [NUM_CH];
    logic [15:0]       w_rdata;

    assign w_wr  = chipselect & ~write_n;
    assign w_reg = reg_e'(address[2:0]);

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_ch = '0;
        if (AW > 3) w_ch = 4'(address >> 3);
    end

    assign w_ch_valid = (w_ch < 4'(NUM_CH));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [COUNT_W-1:0] r_count;
        logic [COUNT_W-1:0] r_period;
        logic [COUNT_W-1:0] r_snap;
        logic [PRESC_W-1:0] r_presc;
        logic [PRESC_W-1:0] r_presc_cnt;
        logic [3:0]         r_ctrl;
        logic               r_run;
        logic               r_to;
        logic               r_zero_d;
        logic               r_force_reload;

        logic        w_sel;
        logic        w_wr_status;
        logic        w_wr_control;
        logic        w_wr_period_l;
        logic        w_wr_period_h;
        logic        w_wr_snap;
        logic        w_wr_presc;
        logic        w_start;
        logic        w_stop;
        logic        w_zero;
        logic        w_tick;
        logic [31:0] w_period32;
        logic [31:0] w_snap32;
        logic [15:0] w_rdata_ch;

        assign w_sel         = w_wr & w_ch_valid & (w_ch == 4'(g));
        assign w_wr_status   = w_sel & (w_reg == REG_STATUS);
        assign w_wr_control  = w_sel & (w_reg == REG_CONTROL);
        assign w_wr_period_l = w_sel & (w_reg == REG_PERIOD_L);
        assign w_wr_period_h = w_sel & (w_reg == REG_PERIOD_H);
        assign w_wr_snap     = w_sel & ((w_reg == REG_SNAP_L) | (w_reg == REG_SNAP_H));
        assign w_wr_presc    = w_sel & (w_reg == REG_PRESCALE);

        assign w_start    = w_wr_control & writedata[2];
        assign w_stop     = w_wr_control & writedata[3];
        assign w_zero     = (r_count == '0);
        assign w_tick     = r_run & (r_presc_cnt == r_presc);
        assign w_period32 = 32'(r_period);
        assign w_snap32   = 32'(r_snap);

        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_count        <= RESET_COUNT;
                r_period       <= RESET_COUNT;
                r_snap         <= '0;
                r_presc        <= '0;
                r_presc_cnt    <= '0;
                r_ctrl         <= '0;
                r_run          <= 1'b0;
                r_to           <= 1'b0;
                r_zero_d       <= 1'b0;
                r_force_reload <= 1'b0;
            end else begin
                r_force_reload <= w_wr_period_l | w_wr_period_h;
                r_zero_d       <= w_zero;

                if (w_wr_period_l) r_period <= COUNT_W'({w_period32[31:16], writedata});
                if (w_wr_period_h) r_period <= COUNT_W'({writedata, w_period32[15:0]});
                if (w_wr_control)  r_ctrl   <= writedata[3:0];
                if (w_wr_presc)    r_presc  <= PRESC_W'(writedata);
                if (w_wr_snap)     r_snap   <= r_count;

                if (w_start || r_force_reload || w_tick) begin
                    r_presc_cnt <= '0;
                end else if (r_run) begin
                    r_presc_cnt <= r_presc_cnt + 1'b1;
                end

                // A one-shot channel parks at zero; only continuous mode reloads on the wrap tick.
                if (r_force_reload) begin
                    r_count <= r_period;
                end else if (w_tick) begin
                    if (!w_zero)        r_count <= r_count - 1'b1;
                    else if (r_ctrl[1]) r_count <= r_period;
                end

                if (w_start) begin
                    r_run <= 1'b1;
                end else if (w_stop || r_force_reload || (w_zero && !r_ctrl[1])) begin
                    r_run <= 1'b0;
                end

                // A software clear beats a coincident zero edge; that timeout is dropped.
                if (w_wr_status) begin
                    r_to <= 1'b0;
                end else if (w_zero && !r_zero_d) begin
                    r_to <= 1'b1;
                end
            end
        end

        assign w_irq[g] = r_to & r_ctrl[0];

        always_comb begin
            w_rdata_ch = '0;
            case (w_reg)
                REG_STATUS:   w_rdata_ch = {14'd0, r_run, r_to};
                REG_CONTROL:  w_rdata_ch = {12'd0, r_ctrl};
                REG_PERIOD_L: w_rdata_ch = w_period32[15:0];
                REG_PERIOD_H: w_rdata_ch = w_period32[31:16];
                REG_SNAP_L:   w_rdata_ch = w_snap32[15:0];
                REG_SNAP_H:   w_rdata_ch = w_snap32[31:16];
                REG_PRESCALE: w_rdata_ch = 16'(r_presc);
                REG_PENDING:  w_rdata_ch = 16'(w_irq);
                default:      w_rdata_ch = '0;
            endcase
        end

        assign w_ch_rdata[g] = w_rdata_ch;
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_valid && (w_ch == 4'(i))) w_rdata = w_ch_rdata[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= w_rdata;
    end

    assign irq = |w_irq;

endmodule

// File: tb/tb_user_timer_multi.sv
// Self-checking bench for user_timer_multi: table-driven register vectors with a read
// scoreboard, plus hand-written sequences for timeout, one-shot, reload, clear-race and reset.
module tb_user_timer_multi;

    localparam int NUM_CH = 2;
    localparam int AW     = 4;

    localparam int R_STATUS   = 0;
    localparam int R_CONTROL  = 1;
    localparam int R_PERIOD_L = 2;
    localparam int R_PERIOD_H = 3;
    localparam int R_SNAP_L   = 4;
    localparam int R_SNAP_H   = 5;
    localparam int R_PRESCALE = 6;
    localparam int R_PENDING  = 7;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [15:0]   writedata;
    logic [15:0]   readdata;
    logic          irq;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] sb_exp  [$];
    string       sb_name [$];

    typedef struct {
        bit          is_wr;
        int          ch;
        int          rg;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [22];

    user_timer_multi #(
        .NUM_CH      (NUM_CH),
        .COUNT_W     (32),
        .RESET_PERIOD(32'h0098_967F),
        .PRESC_W     (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input int ch, input int rg, input logic [15:0] d);
        address    = AW'(ch * 8 + rg);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input int ch, input int rg, input logic [15:0] exp, input string name);
        address    = AW'(ch * 8 + rg);
        chipselect = 1'b1;
        write_n    = 1'b1;
        sb_exp.push_back(exp);
        sb_name.push_back(name);
        @(negedge clk);
        chipselect = 1'b0;
        check(sb_name.pop_front(), 32'(readdata), 32'(sb_exp.pop_front()));
    endtask

    initial begin
        int          first;
        int          seen;
        logic [15:0] status_at;

        vecs[0]  = '{1'b0, 0, R_PERIOD_L, 16'h967F};
        vecs[1]  = '{1'b0, 0, R_PERIOD_H, 16'h0098};
        vecs[2]  = '{1'b0, 0, R_STATUS,   16'h0000};
        vecs[3]  = '{1'b0, 1, R_PERIOD_L, 16'h967F};
        vecs[4]  = '{1'b0, 1, R_PERIOD_H, 16'h0098};
        vecs[5]  = '{1'b0, 0, R_CONTROL,  16'h0000};
        vecs[6]  = '{1'b0, 0, R_SNAP_L,   16'h0000};
        vecs[7]  = '{1'b0, 1, R_PRESCALE, 16'h0000};
        vecs[8]  = '{1'b0, 1, R_PENDING,  16'h0000};
        vecs[9]  = '{1'b1, 0, R_PRESCALE, 16'h01A5};
        vecs[10] = '{1'b0, 0, R_PRESCALE, 16'h00A5};
        vecs[11] = '{1'b1, 1, R_PERIOD_H, 16'hBEEF};
        vecs[12] = '{1'b1, 1, R_PERIOD_L, 16'h1234};
        vecs[13] = '{1'b0, 1, R_PERIOD_H, 16'hBEEF};
        vecs[14] = '{1'b0, 1, R_PERIOD_L, 16'h1234};
        vecs[15] = '{1'b1, 1, R_SNAP_L,   16'h0000};
        vecs[16] = '{1'b0, 1, R_SNAP_L,   16'h1234};
        vecs[17] = '{1'b0, 1, R_SNAP_H,   16'hBEEF};
        vecs[18] = '{1'b1, 1, R_CONTROL,  16'h0003};
        vecs[19] = '{1'b0, 1, R_CONTROL,  16'h0003};
        vecs[20] = '{1'b0, 0, R_PENDING,  16'h0000};
        vecs[21] = '{1'b1, 0, R_PRESCALE, 16'h0000};

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        #12;
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_readdata", 32'(readdata), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            if (vecs[i].is_wr) begin
                wr(vecs[i].ch, vecs[i].rg, vecs[i].data);
                @(negedge clk);
            end else begin
                rd(vecs[i].ch, vecs[i].rg, vecs[i].data, $sformatf("vec%0d", i));
            end
        end
        check("irq_idle", 32'(irq), 32'd0);

        // Ch1 continuous, PERIOD=5: zero after 5 ticks, TO on the following clock.
        wr(1, R_PERIOD_H, 16'h0000);
        wr(1, R_PERIOD_L, 16'h0005);
        wr(1, R_PRESCALE, 16'h0000);
        wr(1, R_CONTROL,  16'h0007);
        first = 0;
        for (int k = 1; k <= 20 && first == 0; k++) begin
            @(negedge clk);
            if (irq) first = k;
        end
        check("a_to_latency", 32'(first), 32'd6);
        rd(0, R_PENDING, 16'h0002, "a_pending");
        wr(1, R_STATUS, 16'h0000);
        check("a_irq_cleared", 32'(irq), 32'd0);
        wr(1, R_CONTROL, 16'h0008);
        wr(1, R_STATUS, 16'h0000);

        // STATUS write on the very clock TO would set: the clear wins.
        wr(1, R_PERIOD_L, 16'h0005);
        @(negedge clk);
        wr(1, R_CONTROL, 16'h0007);
        repeat (5) @(negedge clk);
        wr(1, R_STATUS, 16'h0000);
        check("b_clear_wins_irq", 32'(irq), 32'd0);
        rd(1, R_STATUS, 16'h0002, "b_clear_wins_status");
        wr(1, R_CONTROL, 16'h0008);
        wr(1, R_STATUS, 16'h0000);

        // Ch0 one-shot, PERIOD=3, PRESCALE=3: 3 ticks of 4 clks, then TO one clk later.
        wr(0, R_PERIOD_H, 16'h0000);
        wr(0, R_PERIOD_L, 16'h0003);
        wr(0, R_PRESCALE, 16'h0003);
        @(negedge clk);
        wr(0, R_CONTROL, 16'h0004);
        address    = AW'(0 * 8 + R_STATUS);
        chipselect = 1'b1;
        write_n    = 1'b1;
        first      = 0;
        status_at  = '0;
        for (int m = 1; m <= 20; m++) begin
            @(negedge clk);
            if (first == 0 && readdata[0]) begin
                first     = m - 1;
                status_at = readdata;
            end
        end
        chipselect = 1'b0;
        check("c_to_clks", 32'(first), 32'd13);
        check("c_run_cleared", 32'(status_at), 32'd1);
        wr(0, R_SNAP_L, 16'h0000);
        rd(0, R_SNAP_L, 16'h0000, "c_count_held_l");
        rd(0, R_SNAP_H, 16'h0000, "c_count_held_h");
        wr(0, R_STATUS, 16'h0000);
        address    = AW'(0 * 8 + R_STATUS);
        chipselect = 1'b1;
        seen       = 0;
        for (int m = 0; m < 100; m++) begin
            @(negedge clk);
            if (readdata[0]) seen++;
        end
        chipselect = 1'b0;
        check("c_no_second_to", 32'(seen), 32'd0);

        // Ch0 continuous, PERIOD rewritten mid-count.
        wr(0, R_PRESCALE, 16'h0000);
        wr(0, R_PERIOD_L, 16'd50);
        @(negedge clk);
        wr(0, R_CONTROL, 16'h0006);
        repeat (7) @(negedge clk);
        wr(0, R_PERIOD_L, 16'd10);
        rd(0, R_STATUS, 16'h0002, "d_run_before_reload");
        rd(0, R_STATUS, 16'h0000, "d_run_after_reload");
        wr(0, R_SNAP_L, 16'h0000);
        rd(0, R_SNAP_L, 16'd10, "d_snap_reloaded");
        rd(0, R_PERIOD_L, 16'd10, "d_period_l");

        // START and STOP together: START wins.
        wr(0, R_CONTROL, 16'h000C);
        rd(0, R_STATUS, 16'h0002, "e_start_wins");
        wr(0, R_CONTROL, 16'h0008);
        rd(0, R_STATUS, 16'h0000, "e_stop");

        // Both channels pending, then asynchronous reset.
        wr(0, R_PERIOD_L, 16'h0002);
        @(negedge clk);
        wr(0, R_CONTROL, 16'h0007);
        wr(1, R_PERIOD_L, 16'h0002);
        @(negedge clk);
        wr(1, R_CONTROL, 16'h0007);
        repeat (10) @(negedge clk);
        check("f_irq_both", 32'(irq), 32'd1);
        rd(1, R_PENDING, 16'h0003, "f_pending_both");
        #2;
        reset_n = 1'b0;
        #1;
        check("f_irq_async", 32'(irq), 32'd0);
        check("f_readdata_async", 32'(readdata), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(0, R_PERIOD_L, 16'h967F, "f_period_l");
        rd(1, R_PERIOD_H, 16'h0098, "f_period_h");
        rd(0, R_STATUS,   16'h0000, "f_status0");
        rd(1, R_STATUS,   16'h0000, "f_status1");
        rd(1, R_CONTROL,  16'h0000, "f_control1");
        rd(0, R_PRESCALE, 16'h0000, "f_prescale0");
        rd(1, R_SNAP_L,   16'h0000, "f_snap1");
        rd(0, R_PENDING,  16'h0000, "f_pending");
        check("f_irq_after", 32'(irq), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
